// File: rtl/div_pkg.sv
// Shared types and constants for the divider requester controller.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN,
        DONE
    } state_e;

    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_Q   = 32'h8000_0000;
    localparam logic [31:0] OVF_R   = 32'h0000_0000;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_req_ctrl_if.sv
// Execute-side op port, divider level handshake and writeback result port.
interface div_req_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x;
    logic [31:0]      in_y;
    logic             in_signed;
    logic             in_mod;
    logic [TAG_W-1:0] in_tag;
    logic             flush;

    logic             div;
    logic             div_signed;
    logic [31:0]      div_x;
    logic [31:0]      div_y;
    logic             use_mod;
    logic [31:0]      div_result;
    logic             div_ok;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    // Controller side.
    modport master (
        input  in_valid, in_x, in_y, in_signed, in_mod, in_tag, flush,
        input  div_result, div_ok, out_ready,
        output in_ready, div, div_signed, div_x, div_y, use_mod,
        output out_valid, out_result, out_tag, busy
    );

    // Execute stage, divider and writeback side.
    modport slave (
        output in_valid, in_x, in_y, in_signed, in_mod, in_tag, flush,
        output div_result, div_ok, out_ready,
        input  in_ready, div, div_signed, div_x, div_y, use_mod,
        input  out_valid, out_result, out_tag, busy
    );

endinterface

// File: rtl/div_fast_path.sv
// Resolves divide-by-zero and signed overflow without the iterative divider.
module div_fast_path
    import div_pkg::*;
(
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    input  logic        signed_i,
    input  logic        mod_i,
    output logic        is_fast_o,
    output logic [31:0] fast_result_o
);

    // NOTE: every always_comb output is assigned a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        is_fast_o     = 1'b0;
        fast_result_o = '0;
        if (y_i == '0) begin
            is_fast_o     = 1'b1;
            fast_result_o = mod_i ? x_i : DIV0_Q;
        end else if (signed_i && (x_i == INT_MIN) && (y_i == NEG_ONE)) begin
            is_fast_o     = 1'b1;
            fast_result_o = mod_i ? OVF_R : OVF_Q;
        end
    end

endmodule

// File: rtl/div_req_ctrl.sv
// Requester-side controller: latches an op, holds the divider request until
// completion (or resolves it locally), and presents the result to writeback.
module div_req_ctrl
    import div_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    div_req_ctrl_if.master bus
);

    state_e           state_q, state_d;
    logic [31:0]      x_q, x_d;
    logic [31:0]      y_q, y_d;
    logic             signed_q, signed_d;
    logic             mod_q, mod_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      result_q, result_d;

    logic             in_ready;
    logic             accept;
    logic             is_fast;
    logic [31:0]      fast_result;

    div_fast_path u_fast (
        .x_i          (bus.in_x),
        .y_i          (bus.in_y),
        .signed_i     (bus.in_signed),
        .mod_i        (bus.in_mod),
        .is_fast_o    (is_fast),
        .fast_result_o(fast_result)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        signed_d = signed_q;
        mod_d    = mod_q;
        tag_d    = tag_q;
        result_d = result_q;
        in_ready = 1'b0;

        case (state_q)
            IDLE: in_ready = !bus.flush;
            BUSY: begin
                // A flush landing on the completion cycle simply drops the result.
                if (bus.div_ok) begin
                    if (bus.flush) begin
                        state_d = IDLE;
                    end else begin
                        result_d = bus.div_result;
                        state_d  = DONE;
                    end
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: if (bus.div_ok) state_d = IDLE;
            DONE: begin
                in_ready = bus.out_ready && !bus.flush;
                if (bus.flush || bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        accept = bus.in_valid && in_ready;
        if (accept) begin
            x_d      = bus.in_x;
            y_d      = bus.in_y;
            signed_d = bus.in_signed;
            mod_d    = bus.in_mod;
            tag_d    = bus.in_tag;
            if (is_fast) begin
                result_d = fast_result;
                state_d  = DONE;
            end else begin
                state_d = BUSY;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            signed_q <= 1'b0;
            mod_q    <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            signed_q <= signed_d;
            mod_q    <= mod_d;
            tag_q    <= tag_d;
            result_q <= result_d;
        end
    end

    // Operands only change on accept, which never happens while div is high.
    assign bus.in_ready   = in_ready;
    assign bus.div        = (state_q == BUSY) || (state_q == DRAIN);
    assign bus.div_x      = x_q;
    assign bus.div_y      = y_q;
    assign bus.div_signed = signed_q;
    assign bus.use_mod    = mod_q;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = result_q;
    assign bus.out_tag    = tag_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_div_req_ctrl.sv
// Bench for div_req_ctrl: directed vectors, multi-cycle corner sequences and
// random ops against an arithmetic reference and a behavioural divider.
module tb_div_req_ctrl;

    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    div_req_ctrl_if #(.TAG_W(TAG_W)) bus ();

    div_req_ctrl #(.TAG_W(TAG_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks_n = 0;
    int errors_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_n++;
        if (act !== exp) begin
            errors_n++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks_n++;
        if (act !== exp) begin
            errors_n++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input logic m);
        int sx;
        int sy;
        if (y == 32'h0) return m ? x : 32'hFFFF_FFFF;
        if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return m ? 32'h0 : 32'h8000_0000;
        if (s) begin
            sx = x;
            sy = y;
            return m ? 32'(sx % sy) : 32'(sx / sy);
        end
        return m ? (x % y) : (x / y);
    endfunction

    function automatic logic ref_fast(input logic [31:0] x, input logic [31:0] y, input logic s);
        return (y == 32'h0) || (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    // Behavioural divider: completes lat cycles after div rises, self-resets on completion.
    int unsigned cnt = 0;
    int unsigned lat = 1;
    int unsigned lat_force = 0;
    logic        cmp = 1'b0;

    always @(negedge clk) begin
        if (cmp || !bus.div || reset) begin
            cnt = 0;
            cmp = 1'b0;
        end
        if (bus.div && !reset) begin
            if (cnt == 0) lat = (lat_force != 0) ? lat_force : $urandom_range(1, 5);
            cnt++;
            cmp = (cnt >= lat);
        end
        bus.div_result = cmp ? ref_div(bus.div_x, bus.div_y, bus.div_signed, bus.use_mod)
                             : 32'hDEAD_BEEF;
    end
    assign bus.div_ok = !bus.div || cmp;

    // Divider operands must hold while the request is up.
    logic        prev_div = 1'b0;
    logic [31:0] px = '0;
    logic [31:0] py = '0;
    logic        ps = 1'b0;
    logic        pm = 1'b0;
    always @(negedge clk) begin
        if (prev_div && bus.div) begin
            check("div_x_stable", bus.div_x, px);
            check("div_y_stable", bus.div_y, py);
            check_bit("div_signed_stable", bus.div_signed, ps);
            check_bit("use_mod_stable", bus.use_mod, pm);
        end
        prev_div = bus.div;
        px = bus.div_x;
        py = bus.div_y;
        ps = bus.div_signed;
        pm = bus.use_mod;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                            input logic m, input logic [TAG_W-1:0] tag);
        bus.in_valid  = 1'b1;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_signed = s;
        bus.in_mod    = m;
        bus.in_tag    = tag;
    endtask

    // Returns at the negedge of the cycle after acceptance.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input logic m, input logic [TAG_W-1:0] tag, input string name);
        int n;
        @(negedge clk);
        drive_op(x, y, s, m, tag);
        #1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_bit({name, "_accept"}, n < 50, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int cyc, output logic saw_div,
                              output logic done_prev, output logic first_div);
        cyc       = 0;
        saw_div   = 1'b0;
        done_prev = 1'b0;
        #1;
        first_div = bus.div;
        while (!bus.out_valid && cyc < 60) begin
            if (bus.div) saw_div = 1'b1;
            done_prev = bus.div && bus.div_ok;
            @(negedge clk);
            #1;
            cyc++;
        end
        check_bit({name, "_valid_seen"}, cyc < 60, 1'b1);
    endtask

    task automatic pop(input string name);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check_bit({name, "_valid_dropped"}, bus.out_valid, 1'b0);
        check_bit({name, "_idle"}, bus.busy, 1'b0);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic m, input logic [TAG_W-1:0] tag,
                          input logic [31:0] exp_res, input logic exp_fast,
                          input string name, input int hold);
        int   cyc;
        logic saw_div, done_prev, first_div;
        issue(x, y, s, m, tag, name);
        wait_valid(name, cyc, saw_div, done_prev, first_div);
        check({name, "_result"}, bus.out_result, exp_res);
        check({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
        if (exp_fast) begin
            check({name, "_fast_latency"}, 32'(cyc), 32'd0);
            check_bit({name, "_no_div"}, saw_div, 1'b0);
        end else begin
            check_bit({name, "_div_rise"}, first_div, 1'b1);
            check_bit({name, "_valid_after_ok"}, done_prev, 1'b1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check_bit({name, "_hold_valid"}, bus.out_valid, 1'b1);
            check({name, "_hold_result"}, bus.out_result, exp_res);
        end
        pop(name);
    endtask

    typedef struct {
        logic [31:0]      x;
        logic [31:0]      y;
        logic             s;
        logic             m;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
        logic             fast;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int   n;
        logic [31:0] rx, ry;
        logic rs, rm;

        vecs[0]  = '{32'hFFFF_FFF9, 32'h2,         1'b1, 1'b0, 5'd5,  32'hFFFF_FFFD, 1'b0};
        vecs[1]  = '{32'hFFFF_FFF9, 32'h2,         1'b1, 1'b1, 5'd6,  32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{32'h1234,      32'h0,         1'b0, 1'b0, 5'd7,  32'hFFFF_FFFF, 1'b1};
        vecs[3]  = '{32'h1234,      32'h0,         1'b0, 1'b1, 5'd8,  32'h1234,      1'b1};
        vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd1,  32'h8000_0000, 1'b1};
        vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd2,  32'h0,         1'b1};
        vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd3,  32'h0,         1'b0};
        vecs[7]  = '{32'd100,       32'd7,         1'b0, 1'b0, 5'd4,  32'd14,        1'b0};
        vecs[8]  = '{32'd100,       32'd7,         1'b0, 1'b1, 5'd31, 32'd2,         1'b0};
        vecs[9]  = '{32'd100,       32'hFFFF_FFF9, 1'b1, 1'b0, 5'd0,  32'hFFFF_FFF2, 1'b0};
        vecs[10] = '{32'd100,       32'hFFFF_FFF9, 1'b1, 1'b1, 5'd10, 32'd2,         1'b0};
        vecs[11] = '{32'h1234,      32'h0,         1'b1, 1'b1, 5'd12, 32'h1234,      1'b1};

        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_signed = 1'b0;
        bus.in_mod    = 1'b0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_bit("rst_div", bus.div, 1'b0);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_result", bus.out_result, 32'h0);
        check("rst_out_tag", 32'(bus.out_tag), 32'h0);
        check("rst_div_x", bus.div_x, 32'h0);
        check("rst_div_y", bus.div_y, 32'h0);
        check_bit("rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        #1;
        check_bit("rst_in_ready", bus.in_ready, 1'b1);

        // Directed vectors
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].m, vecs[i].tag,
                   vecs[i].exp, vecs[i].fast, $sformatf("vec%0d", i), i % 3);

        // Flush two cycles into BUSY drains without a result
        lat_force = 8;
        issue(32'd100, 32'd7, 1'b0, 1'b0, 5'd3, "flush_busy");
        #1;
        check_bit("fl_div_rise", bus.div, 1'b1);
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check_bit("fl_in_ready_busy", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        n = 0;
        while (bus.busy && n < 40) begin
            check_bit("fl_div_held", bus.div, 1'b1);
            check("fl_div_x", bus.div_x, 32'd100);
            check("fl_div_y", bus.div_y, 32'd7);
            check_bit("fl_no_out_valid", bus.out_valid, 1'b0);
            check_bit("fl_in_ready_low", bus.in_ready, 1'b0);
            @(negedge clk);
            #1;
            n++;
        end
        check("fl_drain_cycles", 32'(n), 32'd6);
        check_bit("fl_out_valid_idle", bus.out_valid, 1'b0);
        check_bit("fl_in_ready_idle", bus.in_ready, 1'b1);
        lat_force = 0;
        run_op(32'd100, 32'd7, 1'b0, 1'b0, 5'd11, 32'd14, 1'b0, "after_flush", 0);

        // Flush on the completion cycle discards the result
        lat_force = 3;
        issue(32'd50, 32'd5, 1'b0, 1'b0, 5'd9, "flush_ok");
        #1;
        n = 0;
        while (!(bus.div && bus.div_ok) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_bit("flok_ok_seen", n < 20, 1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check_bit("flok_no_valid", bus.out_valid, 1'b0);
        check_bit("flok_idle", bus.busy, 1'b0);
        check_bit("flok_div_low", bus.div, 1'b0);
        lat_force = 0;

        // Flush alongside in_valid in IDLE: op not accepted
        @(negedge clk);
        drive_op(32'd9, 32'd3, 1'b0, 1'b0, 5'd1);
        bus.flush = 1'b1;
        #1;
        check_bit("fli_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        #1;
        check_bit("fli_idle", bus.busy, 1'b0);
        check_bit("fli_no_div", bus.div, 1'b0);

        // Flush in DONE drops out_valid next cycle
        issue(32'h1234, 32'h0, 1'b0, 1'b0, 5'd2, "flush_done");
        #1;
        check_bit("fld_valid", bus.out_valid, 1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check_bit("fld_valid_dropped", bus.out_valid, 1'b0);
        check_bit("fld_idle", bus.busy, 1'b0);

        // Backpressure in DONE, then accept a new op on the release cycle
        issue(32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0, 5'd9, "bp");
        begin
            int   cyc;
            logic sd, dp, fd;
            wait_valid("bp", cyc, sd, dp, fd);
        end
        drive_op(32'h1234, 32'h0, 1'b0, 1'b1, 5'd4);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_bit("bp_valid_held", bus.out_valid, 1'b1);
            check("bp_result_held", bus.out_result, 32'hFFFF_FFFD);
            check("bp_tag_held", 32'(bus.out_tag), 32'd9);
            check_bit("bp_in_ready_low", bus.in_ready, 1'b0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        check_bit("bp_in_ready_release", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        #1;
        check_bit("bp_next_valid", bus.out_valid, 1'b1);
        check("bp_next_result", bus.out_result, 32'h1234);
        check("bp_next_tag", 32'(bus.out_tag), 32'd4);
        pop("bp_next");

        // Reset mid-BUSY clears everything in one edge
        lat_force = 10;
        issue(32'd100, 32'd3, 1'b0, 1'b0, 5'd2, "rst_mid");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_bit("rm_div", bus.div, 1'b0);
        check_bit("rm_out_valid", bus.out_valid, 1'b0);
        check_bit("rm_busy", bus.busy, 1'b0);
        check("rm_div_x", bus.div_x, 32'h0);
        check("rm_out_tag", 32'(bus.out_tag), 32'h0);
        lat_force = 0;
        run_op(32'hFFFF_FFFF, 32'd3, 1'b0, 1'b1, 5'd13, 32'h0, 1'b0, "post_reset", 0);

        // Random ops against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       ry = 32'h0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = $urandom_range(1, 15);
                default: ry = $urandom;
            endcase
            rx = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            rs = 1'($urandom_range(0, 1));
            rm = 1'($urandom_range(0, 1));
            run_op(rx, ry, rs, rm, 5'($urandom_range(0, 31)), ref_div(rx, ry, rs, rm),
                   ref_fast(rx, ry, rs), $sformatf("rand%0d", i), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

endmodule
